// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   ID-stage hazard controller for the branch comparator.
//   - forwardcmpsrcA/B select the comparator operands (0 qa/qb, 1 resultW, 2 alu_outM).
//   - stallF/stallD/flushE hold the front end and bubble ID/EX while a branch
//     waits for an operand still in EX (any write) or in MEM (load).
//   - flushD clears IF/ID on a jump or taken branch, never while stalled.
//   - A stall-episode FSM with a saturating watchdog raises the sticky hazard_err
//     when an episode runs longer than MAX_STALL cycles.
//   - br_cnt/taken_cnt/stall_cnt statistics exist only when the macro
//     BRANCH_HAZARD_STATS_EN is defined; otherwise they read constant 0.
// Ports
//   clk, rst (sync, active-high); branchD, jD, rsD, rtD; writeregE/M/W,
//   regwriteE/M/W, memtoregE/M, pcsrcD in; forwardcmpsrcA/B, stallF, stallD,
//   flushE, flushD, hazard_err, br_cnt, taken_cnt, stall_cnt out.
module branch_hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int MAX_STALL = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchD,
    input  logic             jD,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic [1:0]       pcsrcD,
    output logic [1:0]       forwardcmpsrcA,
    output logic [1:0]       forwardcmpsrcB,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             flushD,
    output logic             hazard_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Watchdog wide enough to hold MAX_STALL+1 so an overrun is visible.
    localparam int WD_W = $clog2(MAX_STALL + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL);

    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t          state, state_n;
    logic [WD_W-1:0] wd, wd_n;
    logic            stall_req;

    logic rs_nz, rt_nz;
    logic m_rs, m_rt, w_rs, w_rt, e_hit, ld_hit;

    assign rs_nz = (rsD != '0);
    assign rt_nz = (rtD != '0);

    // MEM forwarding excludes loads: their data is not ready at alu_outM.
    assign m_rs = regwriteM & ~memtoregM & (writeregM == rsD) & rs_nz;
    assign m_rt = regwriteM & ~memtoregM & (writeregM == rtD) & rt_nz;
    assign w_rs = regwriteW & (writeregW == rsD) & rs_nz;
    assign w_rt = regwriteW & (writeregW == rtD) & rt_nz;

    always_comb begin
        forwardcmpsrcA = 2'd0;
        if (m_rs)      forwardcmpsrcA = 2'd2;
        else if (w_rs) forwardcmpsrcA = 2'd1;
    end

    always_comb begin
        forwardcmpsrcB = 2'd0;
        if (m_rt)      forwardcmpsrcB = 2'd2;
        else if (w_rt) forwardcmpsrcB = 2'd1;
    end

    assign e_hit  = regwriteE & (((writeregE == rsD) & rs_nz) | ((writeregE == rtD) & rt_nz));
    assign ld_hit = memtoregM & (((writeregM == rsD) & rs_nz) | ((writeregM == rtD) & rt_nz));

    assign stall_req = branchD & (e_hit | ld_hit);
    assign stallF    = stall_req;
    assign stallD    = stall_req;
    assign flushE    = stall_req;
    assign flushD    = (pcsrcD != 2'b00) & ~stallD;

    always_comb begin
        state_n = state;
        wd_n    = wd;
        case (state)
            IDLE: begin
                if (stall_req) begin
                    state_n = STALL;
                    wd_n    = WD_W'(1);
                end
            end
            STALL: begin
                if (stall_req) begin
                    if (wd != '1) wd_n = wd + WD_W'(1);
                end else begin
                    state_n = RESOLVE;
                end
            end
            RESOLVE: begin
                if (stall_req) begin
                    state_n = STALL;
                    wd_n    = WD_W'(1);
                end else begin
                    state_n = IDLE;
                    wd_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                wd_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wd         <= '0;
            hazard_err <= 1'b0;
        end else begin
            state      <= state_n;
            wd         <= wd_n;
            // Flag on the same edge the watchdog crosses the limit.
            hazard_err <= hazard_err | (wd_n > WD_LIMIT);
        end
    end

`ifdef BRANCH_HAZARD_STATS_EN
    logic unused_memtoreg_e;
    assign unused_memtoreg_e = memtoregE;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if ((branchD | jD) & ~stallD) br_cnt <= br_cnt + CNT_W'(1);
            if (flushD)                   taken_cnt <= taken_cnt + CNT_W'(1);
            if (stallD)                   stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    // jD only feeds the statistics; memtoregE is implied by regwriteE for the EX check.
    logic unused_inputs;
    assign unused_inputs = jD | memtoregE;

    assign br_cnt    = '0;
    assign taken_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             branchD, jD;
    logic [REG_W-1:0] rsD, rtD, writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic [1:0]       pcsrcD;
    logic [1:0]       forwardcmpsrcA, forwardcmpsrcB;
    logic             stallF, stallD, flushE, flushD, hazard_err;
    logic [CNT_W-1:0] br_cnt, taken_cnt, stall_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.REG_W(REG_W), .MAX_STALL(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .branchD(branchD), .jD(jD), .rsD(rsD), .rtD(rtD),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .pcsrcD(pcsrcD),
        .forwardcmpsrcA(forwardcmpsrcA), .forwardcmpsrcB(forwardcmpsrcB),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .flushD(flushD),
        .hazard_err(hazard_err), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        branchD = 0; jD = 0; rsD = '0; rtD = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; pcsrcD = 2'b00;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, ".stallF"}, 32'(stallF), 32'(exp));
        check({tag, ".stallD"}, 32'(stallD), 32'(exp));
        check({tag, ".flushE"}, 32'(flushE), 32'(exp));
    endtask

    task automatic check_counters(input string tag, input int unsigned b,
                                  input int unsigned t, input int unsigned s);
`ifdef BRANCH_HAZARD_STATS_EN
        check({tag, ".br_cnt"},    br_cnt,    b);
        check({tag, ".taken_cnt"}, taken_cnt, t);
        check({tag, ".stall_cnt"}, stall_cnt, s);
`else
        check({tag, ".br_cnt"},    br_cnt,    0);
        check({tag, ".taken_cnt"}, taken_cnt, 0);
        check({tag, ".stall_cnt"}, stall_cnt, 0);
        if (b + t + s == 0) begin end
`endif
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #1;
        tick(); tick();
        check("rst.hazard_err", 32'(hazard_err), 0);
        check_stall("rst", 0);
        check("rst.flushD", 32'(flushD), 0);
        check("rst.fwdA", 32'(forwardcmpsrcA), 0);
        check_counters("rst", 0, 0, 0);
        rst = 0;
        tick();

        // T1: MEM beats WB; a load in MEM is not forwarded and stalls instead.
        branchD = 1; rsD = 5; regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5;
        #1;
        check("t1.fwdA", 32'(forwardcmpsrcA), 2);
        check_stall("t1", 0);
        memtoregM = 1; #1;
        check("t1ld.fwdA", 32'(forwardcmpsrcA), 1);
        check_stall("t1ld", 1);
        memtoregM = 0; regwriteM = 0; #1;
        check("t1wb.fwdA", 32'(forwardcmpsrcA), 1);
        clear_inputs(); tick();

        // T2: ALU result in EX stalls one cycle, then forwarded from MEM.
        branchD = 1; rtD = 8; regwriteE = 1; writeregE = 8; #1;
        check_stall("t2a", 1);
        check("t2a.fwdB", 32'(forwardcmpsrcB), 0);
        tick();
        regwriteE = 0; writeregE = '0; regwriteM = 1; writeregM = 8; #1;
        check_stall("t2b", 0);
        check("t2b.fwdB", 32'(forwardcmpsrcB), 2);
        tick();
        clear_inputs(); tick();

        // T3: load then branch: two stall cycles, then forward from WB.
        branchD = 1; rsD = 9; regwriteE = 1; memtoregE = 1; writeregE = 9; #1;
        check_stall("t3a", 1);
        tick();
        regwriteE = 0; memtoregE = 0; writeregE = '0;
        regwriteM = 1; memtoregM = 1; writeregM = 9; #1;
        check_stall("t3b", 1);
        check("t3b.fwdA", 32'(forwardcmpsrcA), 0);
        tick();
        regwriteM = 0; memtoregM = 0; writeregM = '0; regwriteW = 1; writeregW = 9; #1;
        check_stall("t3c", 0);
        check("t3c.fwdA", 32'(forwardcmpsrcA), 1);
        tick();
        clear_inputs(); tick(); tick();
        check("t3.hazard_err", 32'(hazard_err), 0);

        // T4: redirect flushes IF/ID only when not stalled.
        branchD = 1; pcsrcD = 2'b10; #1;
        check("t4a.flushD", 32'(flushD), 1);
        jD = 1; pcsrcD = 2'b01; rsD = 3; regwriteE = 1; writeregE = 3; #1;
        check("t4b.flushD", 32'(flushD), 0);
        check_stall("t4b", 1);
        regwriteE = 0; #1;
        check("t4c.flushD", 32'(flushD), 1);
        clear_inputs();
        // No branch in ID means no stall even with a matching EX write.
        rsD = 4; regwriteE = 1; writeregE = 4; #1;
        check_stall("t4nobr", 0);
        clear_inputs(); tick();

        // T5: register 0 never matches.
        branchD = 1; rsD = '0; regwriteE = 1; writeregE = '0;
        regwriteM = 1; writeregM = '0; regwriteW = 1; writeregW = '0; #1;
        check_stall("t5", 0);
        check("t5.fwdA", 32'(forwardcmpsrcA), 0);
        check("t5.fwdB", 32'(forwardcmpsrcB), 0);
        clear_inputs();

        // T6: watchdog and statistics from a fresh reset.
        rst = 1; tick(); rst = 0;
        check_counters("t6rst", 0, 0, 0);
        branchD = 1; rtD = 7; regwriteE = 1; writeregE = 7;
        tick(); tick();
        check("t6.err_2cyc", 32'(hazard_err), 0);
        tick();
        check_counters("t6.3cyc", 0, 0, 3);
        tick();
        check("t6.err_set", 32'(hazard_err), 1);
        clear_inputs();
        branchD = 1; pcsrcD = 2'b10;
        tick();
        check_counters("t6.taken", 1, 1, 4);
        clear_inputs(); tick(); tick();
        check("t6.err_sticky", 32'(hazard_err), 1);
        rst = 1; tick(); rst = 0; #1;
        check("t6.err_cleared", 32'(hazard_err), 0);
        check_counters("t6.final", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
